fetch_queue: RTL and testbench

Instruction fetch queue between the IF2 stage and ID. Each cycle it accepts up to two fetched instructions, in program order, with their PCs and branch-prediction tags. It presents up to two head entries to decode. It back-pressures the IF1/IF2 pipeline through a stall output. It drops its whole contents on a branch-misprediction flush.

---
 rtl/fq_pkg.sv | 19 +
 rtl/fq_storage.sv | 42 ++++
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// fq_pkg: shared types and helpers for the instruction fetch queue.
//   fq_entry_t  : one queued instruction (PC, instruction word, branch type + predicted target)
//   FQ_BRTYPE_W : width of the branch-type field held above the 32-bit predicted target
//   fq_popcnt2  : number of set bits in a 2-bit slot-valid vector
package fq_pkg;

    localparam int FQ_BRTYPE_W = 2;

    typedef struct packed {
        logic [31:0]               pc;
        logic [31:0]               inst;
        logic [FQ_BRTYPE_W+31:0]   brtype_pcpre;
    } fq_entry_t;

    function automatic logic [1:0] fq_popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH-entry register array backing the fetch queue.
// Two write ports, two asynchronous read ports, and no reset on the contents.
// Ports:
//   clk                      clock
//   i_we0/i_waddr0/i_wdata0  write port 0
//   i_we1/i_waddr1/i_wdata1  write port 1 (never addresses the same entry as port 0)
//   i_raddr0/o_rdata0        read port 0 (head)
//   i_raddr1/o_rdata1        read port 1 (head+1)
module fq_storage
    import fq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we0,
    input  logic [AW-1:0]   i_waddr0,
    input  fq_entry_t       i_wdata0,
    input  logic            i_we1,
    input  logic [AW-1:0]   i_waddr1,
    input  fq_entry_t       i_wdata1,
    input  logic [AW-1:0]   i_raddr0,
    input  logic [AW-1:0]   i_raddr1,
    output fq_entry_t       o_rdata0,
    output fq_entry_t       o_rdata1
);

    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between IF2 and ID.
// Accepts up to two instructions per cycle (compacted, in program order), presents the head
// and head+1 entries to decode, stalls fetch when a full pair might not fit, and empties on a
// branch-misprediction flush. Reset (rstn, synchronous, active-low) behaves like a flush.
// Optional feature: define FQ_BYPASS_EN to let an empty queue forward its inputs to decode
// combinationally (zero-cycle push-to-present latency).
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   i_PC1/i_inst1/i_brtype_pcpre_1    fetched slot 1 (older)
//   i_PC2/i_inst2/i_brtype_pcpre_2    fetched slot 2
//   i_is_valid                        {slot 2 valid, slot 1 valid}
//   flush_BR                          branch-misprediction flush
//   i_ID_ready                        decode takes the presented entries this cycle
//   o_PC*/o_inst*/o_brtype_pcpre_*    head (1) and head+1 (2) entries, zero when invalid
//   o_is_valid                        {head+1 valid, head valid}
//   o_stall_FQ                        queue cannot accept a full pair
module fetch_queue
    import fq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_PC1,
    input  logic [31:0] i_PC2,
    input  logic [31:0] i_inst1,
    input  logic [31:0] i_inst2,
    input  logic [33:0] i_brtype_pcpre_1,
    input  logic [33:0] i_brtype_pcpre_2,
    input  logic [1:0]  i_is_valid,
    input  logic        flush_BR,
    input  logic        i_ID_ready,
    output logic [31:0] o_PC1,
    output logic [31:0] o_PC2,
    output logic [31:0] o_inst1,
    output logic [31:0] o_inst2,
    output logic [33:0] o_brtype_pcpre_1,
    output logic [33:0] o_brtype_pcpre_2,
    output logic [1:0]  o_is_valid,
    output logic        o_stall_FQ
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    fq_entry_t     w_in1;
    fq_entry_t     w_in2;
    fq_entry_t     w_first;
    fq_entry_t     w_rd0;
    fq_entry_t     w_rd1;
    fq_entry_t     w_h0;
    fq_entry_t     w_h1;
    logic [1:0]    w_vld;
    logic          w_empty;
    logic          w_bypass;
    logic          w_push_en;
    logic [1:0]    w_pushed;
    logic [1:0]    w_popped;

    assign w_in1 = '{pc: i_PC1, inst: i_inst1, brtype_pcpre: i_brtype_pcpre_1};
    assign w_in2 = '{pc: i_PC2, inst: i_inst2, brtype_pcpre: i_brtype_pcpre_2};

    // Compaction: the oldest valid slot always lands at tail.
    assign w_first = i_is_valid[0] ? w_in1 : w_in2;

    assign w_empty    = (r_count == '0);
    // Stall looks only at the registered count, so a same-cycle pop cannot release it.
    assign o_stall_FQ = (r_count > CW'(DEPTH - 2));

`ifdef FQ_BYPASS_EN
    assign w_bypass = w_empty && !flush_BR && (i_is_valid != 2'b00);
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_vld = {r_count >= CW'(2), r_count >= CW'(1)};
        w_h0  = w_rd0;
        w_h1  = w_rd1;
        if (w_bypass) begin
            w_vld = {&i_is_valid, 1'b1};
            w_h0  = w_first;
            w_h1  = w_in2;
        end
        if (flush_BR) begin
            w_vld = 2'b00;
        end
    end

    assign o_is_valid       = w_vld;
    assign o_PC1            = w_vld[0] ? w_h0.pc           : '0;
    assign o_inst1          = w_vld[0] ? w_h0.inst         : '0;
    assign o_brtype_pcpre_1 = w_vld[0] ? w_h0.brtype_pcpre : '0;
    assign o_PC2            = w_vld[1] ? w_h1.pc           : '0;
    assign o_inst2          = w_vld[1] ? w_h1.inst         : '0;
    assign o_brtype_pcpre_2 = w_vld[1] ? w_h1.brtype_pcpre : '0;

    // Bypassed entries consumed by decode never enter storage; queue head does not move.
    assign w_push_en = !o_stall_FQ && !flush_BR && !(w_bypass && i_ID_ready);
    assign w_pushed  = w_push_en ? fq_popcnt2(i_is_valid) : 2'd0;
    assign w_popped  = (i_ID_ready && !w_bypass) ? fq_popcnt2(w_vld) : 2'd0;

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .i_we0    (w_push_en && (i_is_valid != 2'b00)),
        .i_waddr0 (r_tail),
        .i_wdata0 (w_first),
        .i_we1    (w_push_en && (i_is_valid == 2'b11)),
        .i_waddr1 (r_tail + AW'(1)),
        .i_wdata1 (w_in2),
        .i_raddr0 (r_head),
        .i_raddr1 (r_head + AW'(1)),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    always_ff @(posedge clk) begin
        if (!rstn || flush_BR) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_popped);
            r_tail  <= r_tail + AW'(w_pushed);
            r_count <= r_count + CW'(w_pushed) - CW'(w_popped);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue. A queue-based model predicts the
// outputs every cycle; directed sequences pin the model with literal expectations, then
// randomized traffic exercises push/pop/flush/stall interactions.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] i_PC1, i_PC2, i_inst1, i_inst2;
    logic [33:0] i_brtype_pcpre_1, i_brtype_pcpre_2;
    logic [1:0]  i_is_valid;
    logic        flush_BR;
    logic        i_ID_ready;
    logic [31:0] o_PC1, o_PC2, o_inst1, o_inst2;
    logic [33:0] o_brtype_pcpre_1, o_brtype_pcpre_2;
    logic [1:0]  o_is_valid;
    logic        o_stall_FQ;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_PC1            (i_PC1),
        .i_PC2            (i_PC2),
        .i_inst1          (i_inst1),
        .i_inst2          (i_inst2),
        .i_brtype_pcpre_1 (i_brtype_pcpre_1),
        .i_brtype_pcpre_2 (i_brtype_pcpre_2),
        .i_is_valid       (i_is_valid),
        .flush_BR         (flush_BR),
        .i_ID_ready       (i_ID_ready),
        .o_PC1            (o_PC1),
        .o_PC2            (o_PC2),
        .o_inst1          (o_inst1),
        .o_inst2          (o_inst2),
        .o_brtype_pcpre_1 (o_brtype_pcpre_1),
        .o_brtype_pcpre_2 (o_brtype_pcpre_2),
        .o_is_valid       (o_is_valid),
        .o_stall_FQ       (o_stall_FQ)
    );

    typedef logic [97:0] ent_t;

    ent_t        q[$];
    bit          model_on = 1'b0;
    int          n_chk    = 0;
    int          n_pass   = 0;
    logic [31:0] pc_next  = 32'h1c000000;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // What decode must see this cycle, given the queued contents and current inputs.
    function automatic void expect_out(output logic [1:0] v, output ent_t e1, output ent_t e2,
                                       output bit byp);
        ent_t a = {i_PC1, i_inst1, i_brtype_pcpre_1};
        ent_t b = {i_PC2, i_inst2, i_brtype_pcpre_2};
        v = 2'b00; e1 = '0; e2 = '0; byp = 1'b0;
        if (flush_BR) return;
`ifdef FQ_BYPASS_EN
        if (q.size() == 0 && i_is_valid != 2'b00) begin
            byp = 1'b1;
            if (i_is_valid == 2'b10) begin
                v = 2'b01; e1 = b;
            end else begin
                v = i_is_valid; e1 = a;
                if (v[1]) e2 = b;
            end
            return;
        end
`endif
        if (q.size() >= 1) begin v[0] = 1'b1; e1 = q[0]; end
        if (q.size() >= 2) begin v[1] = 1'b1; e2 = q[1]; end
    endfunction

    // Model state update at each active edge.
    always @(posedge clk) begin
        logic [1:0] v;
        ent_t       e1, e2;
        bit         byp, full;
        if (!rstn) begin
            q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            if (flush_BR) begin
                q.delete();
            end else begin
                expect_out(v, e1, e2, byp);
                full = (q.size() > DEPTH - 2);
                if (!byp && i_ID_ready) begin
                    for (int k = 0; k < int'(v[0]) + int'(v[1]); k++) void'(q.pop_front());
                end
                if (!full && !(byp && i_ID_ready)) begin
                    if (i_is_valid[0]) q.push_back({i_PC1, i_inst1, i_brtype_pcpre_1});
                    if (i_is_valid[1]) q.push_back({i_PC2, i_inst2, i_brtype_pcpre_2});
                end
            end
        end
    end

    // Per-cycle comparison on the inactive edge.
    always @(negedge clk) begin
        logic [1:0] v;
        ent_t       e1, e2;
        bit         byp;
        if (model_on) begin
            expect_out(v, e1, e2, byp);
            chk("valid", 128'(o_is_valid), 128'(v));
            chk("stall", 128'(o_stall_FQ), 128'(q.size() > DEPTH - 2));
            chk("head0", 128'({o_PC1, o_inst1, o_brtype_pcpre_1}), 128'(e1));
            chk("head1", 128'({o_PC2, o_inst2, o_brtype_pcpre_2}), 128'(e2));
        end
    end

    task automatic idle();
        i_is_valid = 2'b00;
        i_ID_ready = 1'b0;
        flush_BR   = 1'b0;
    endtask

    task automatic drive(input logic [1:0] v, input bit rdy, input bit fl);
        i_is_valid       = v;
        i_ID_ready       = rdy;
        flush_BR         = fl;
        i_PC1            = pc_next;
        i_PC2            = pc_next + 32'd4;
        i_inst1          = ~pc_next;
        i_inst2          = ~(pc_next + 32'd4);
        i_brtype_pcpre_1 = {pc_next[3:2], pc_next ^ 32'hffff0000};
        i_brtype_pcpre_2 = {pc_next[4:3], pc_next ^ 32'h0000ffff};
        pc_next          = pc_next + 32'd8;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    // Pops everything with decode ready; returns entries seen and the last PC taken.
    task automatic drain(output int n, output logic [31:0] last);
        n    = 0;
        last = '0;
        for (int i = 0; i < 20; i++) begin
            i_ID_ready = 1'b1;
            #1;
            if (o_is_valid == 2'b00) break;
            n += int'(o_is_valid[0]) + int'(o_is_valid[1]);
            last = o_is_valid[1] ? o_PC2 : o_PC1;
            tick();
        end
        i_ID_ready = 1'b0;
    endtask

    initial begin
        int          n;
        logic [31:0] last;
        int          rdy_thr;

        rstn = 1'b0;
        i_PC1 = '0; i_PC2 = '0; i_inst1 = '0; i_inst2 = '0;
        i_brtype_pcpre_1 = '0; i_brtype_pcpre_2 = '0;
        idle();
        repeat (3) tick();
        chk("rst_valid", 128'(o_is_valid), 128'(2'b00));
        chk("rst_stall", 128'(o_stall_FQ), 128'(1'b0));
        chk("rst_pc1", 128'(o_PC1), 128'(32'h0));
        rstn = 1'b1;

        // Pair push, visible one cycle later.
        pc_next = 32'h1c000000;
        drive(2'b11, 1'b0, 1'b0);
        tick();
        chk("pair_valid", 128'(o_is_valid), 128'(2'b11));
        chk("pair_pc1", 128'(o_PC1), 128'(32'h1c000000));
        chk("pair_pc2", 128'(o_PC2), 128'(32'h1c000004));

        // Flush masks, then slot-2-only push compacts to head.
        drive(2'b00, 1'b0, 1'b1);
        #1;
        chk("flush_mask", 128'(o_is_valid), 128'(2'b00));
        tick();
        pc_next = 32'h1c000010;
        drive(2'b10, 1'b0, 1'b0);
        tick();
        chk("slot2_valid", 128'(o_is_valid), 128'(2'b01));
        chk("slot2_pc1", 128'(o_PC1), 128'(32'h1c000014));
        chk("slot2_pc2_zero", 128'(o_PC2), 128'(32'h0));

        // Fill to DEPTH with four pairs; fifth pair ignored.
        drive(2'b00, 1'b0, 1'b1);
        tick();
        pc_next = 32'h1c000100;
        repeat (3) begin drive(2'b11, 1'b0, 1'b0); tick(); end
        chk("fill6_stall", 128'(o_stall_FQ), 128'(1'b0));
        drive(2'b11, 1'b0, 1'b0);
        tick();
        chk("fill8_stall", 128'(o_stall_FQ), 128'(1'b1));
        drive(2'b11, 1'b0, 1'b0);
        tick();
        chk("fill8_hold", 128'(o_stall_FQ), 128'(1'b1));
        drain(n, last);
        chk("fill8_count", 128'(n), 128'(8));
        chk("fill8_last", 128'(last), 128'(32'h1c00011c));

        // Count 7: push under stall is dropped while decode pops two; then wrap past entry 7.
        drive(2'b00, 1'b0, 1'b1);
        tick();
        pc_next = 32'h1c000200;
        repeat (3) begin drive(2'b11, 1'b0, 1'b0); tick(); end
        drive(2'b01, 1'b0, 1'b0);
        tick();
        chk("fill7_stall", 128'(o_stall_FQ), 128'(1'b1));
        drive(2'b01, 1'b1, 1'b0);
        #1;
        chk("pop2_valid", 128'(o_is_valid), 128'(2'b11));
        chk("pop2_pc1", 128'(o_PC1), 128'(32'h1c000200));
        tick();
        chk("pop2_unstall", 128'(o_stall_FQ), 128'(1'b0));
        chk("pop2_next_pc1", 128'(o_PC1), 128'(32'h1c000208));
        drive(2'b11, 1'b0, 1'b0);
        tick();
        chk("wrap_stall", 128'(o_stall_FQ), 128'(1'b1));
        drain(n, last);
        chk("wrap_count", 128'(n), 128'(7));
        chk("wrap_last", 128'(last), 128'(32'h1c00022c));

        // Flush with a simultaneous push: pair lost.
        pc_next = 32'h1c000300;
        repeat (2) begin drive(2'b11, 1'b0, 1'b0); tick(); end
        drive(2'b01, 1'b0, 1'b0);
        tick();
        drive(2'b11, 1'b0, 1'b1);
        #1;
        chk("flushpush_mask", 128'(o_is_valid), 128'(2'b00));
        chk("flushpush_pc1", 128'(o_PC1), 128'(32'h0));
        tick();
        chk("flushpush_empty", 128'(o_is_valid), 128'(2'b00));
        chk("flushpush_stall", 128'(o_stall_FQ), 128'(1'b0));
        tick();
        chk("flushpush_lost", 128'(o_is_valid), 128'(2'b00));

`ifdef FQ_BYPASS_EN
        pc_next = 32'h1c000400;
        drive(2'b11, 1'b1, 1'b0);
        #1;
        chk("byp_valid", 128'(o_is_valid), 128'(2'b11));
        chk("byp_pc1", 128'(o_PC1), 128'(32'h1c000400));
        chk("byp_pc2", 128'(o_PC2), 128'(32'h1c000404));
        tick();
        chk("byp_empty", 128'(o_is_valid), 128'(2'b00));
`endif

        // Randomized traffic with varying decode throughput.
        for (int c = 0; c < 3000; c++) begin
            rdy_thr          = 1 + (c / 600) % 4;
            i_is_valid       = 2'($urandom_range(0, 3));
            i_ID_ready       = ($urandom_range(0, 3) < rdy_thr);
            flush_BR         = ($urandom_range(0, 31) == 0);
            i_PC1            = $urandom;
            i_PC2            = $urandom;
            i_inst1          = $urandom;
            i_inst2          = $urandom;
            i_brtype_pcpre_1 = {2'($urandom_range(0, 3)), 32'($urandom)};
            i_brtype_pcpre_2 = {2'($urandom_range(0, 3)), 32'($urandom)};
            @(posedge clk);
            #1;
        end
        idle();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
